// File: rtl/smg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with guard blanking, PWM brightness,
// per-digit blank mask and a frame-start strobe; inputs are snapshotted once per frame.
module smg_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SEG_W        = 8,
    parameter int SCAN_CYCLES  = 55,
    parameter int BLANK_CYCLES = 4,
    parameter int BRIGHT_W     = 4,
    parameter int SEG_ACT_LOW  = 0,
    parameter int DIG_ACT_LOW  = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Enable,
    input  logic [NUM_DIGITS*SEG_W-1:0]   Digit_Data,
    input  logic [NUM_DIGITS-1:0]         Blank_Mask,
    input  logic [BRIGHT_W-1:0]           Brightness,
    output logic [SEG_W-1:0]              Row_Scan_Sig,
    output logic [NUM_DIGITS-1:0]         Column_Scan_Sig,
    output logic [$clog2(NUM_DIGITS)-1:0] Digit_Idx,
    output logic                          Frame_Start
);

    localparam int CNT_W = $clog2(SCAN_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = CNT_W + BRIGHT_W;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DW-1:0]         ACT_V    = DW'(SCAN_CYCLES - BLANK_CYCLES);
    localparam logic [DW-1:0]         BLANK_V  = DW'(BLANK_CYCLES);
    localparam logic [SEG_W-1:0]      SEG_OFF  = {SEG_W{SEG_ACT_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACT_LOW != 0}};

    logic [CNT_W-1:0]            count, count_nxt;
    logic [IDX_W-1:0]            idx, idx_nxt;
    logic [NUM_DIGITS*SEG_W-1:0] digit_sh;
    logic [NUM_DIGITS-1:0]       mask_sh;
    logic [BRIGHT_W-1:0]         bright_sh;
    logic [DW-1:0]               prod, duty, offset;
    logic                        frame_pos, lit;
    logic [SEG_W-1:0]            seg_lit;
    logic [NUM_DIGITS-1:0]       sel_lit;

    assign frame_pos = (count == '0) && (idx == '0);

    always_comb begin
        count_nxt = count;
        idx_nxt   = idx;
        if (!Enable) begin
            count_nxt = '0;
            idx_nxt   = '0;
        end else if (count == CNT_LAST) begin
            count_nxt = '0;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            count_nxt = count + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
            idx   <= '0;
        end else begin
            count <= count_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            digit_sh  <= '0;
            mask_sh   <= '0;
            bright_sh <= '0;
        end else if (frame_pos) begin
            digit_sh  <= Digit_Data;
            mask_sh   <= Blank_Mask;
            bright_sh <= Brightness;
        end
    end

    // Full-scale code maps to the whole active window rather than ACT*(2^W-1)/2^W.
    always_comb begin
        prod    = ACT_V * DW'(bright_sh);
        duty    = (bright_sh == '1) ? ACT_V : (prod >> BRIGHT_W);
        offset  = DW'(count) - BLANK_V;
        lit     = Enable && (DW'(count) >= BLANK_V) && (offset < duty) && !mask_sh[idx];
        seg_lit = digit_sh[int'(idx)*SEG_W +: SEG_W];
        sel_lit = NUM_DIGITS'(1) << idx;
    end

    // XOR with the off level applies output polarity in one place.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Row_Scan_Sig    <= SEG_OFF;
            Column_Scan_Sig <= DIG_OFF;
            Digit_Idx       <= '0;
            Frame_Start     <= 1'b0;
        end else begin
            Row_Scan_Sig    <= lit ? (seg_lit ^ SEG_OFF) : SEG_OFF;
            Column_Scan_Sig <= lit ? (sel_lit ^ DIG_OFF) : DIG_OFF;
            Digit_Idx       <= idx;
            Frame_Start     <= Enable && frame_pos;
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Scoreboard bench for smg_scan_ctrl: a time-based reference queues per-cycle expectations,
// a negedge monitor checks both a default-polarity and an inverted-polarity instance.
module tb_smg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [47:0] data;
    logic [5:0]  mask;
    logic [3:0]  bright;

    logic [7:0] row_a, row_b;
    logic [5:0] col_a, col_b;
    logic [2:0] idx_a, idx_b;
    logic       fs_a, fs_b;

    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        int unsigned due;
        logic [7:0]  seg;
        logic [5:0]  sel;
        logic [2:0]  idx;
        logic        fs;
    } exp_t;

    exp_t sb[$];

    // reference state: enabled cycles since scan start plus frame snapshot
    int unsigned m_t = 0;
    logic [47:0] m_data   = '0;
    logic [5:0]  m_mask   = '0;
    logic [3:0]  m_bright = '0;

    smg_scan_ctrl dut_a (
        .CLK(clk), .RST(rst), .Enable(en), .Digit_Data(data), .Blank_Mask(mask),
        .Brightness(bright), .Row_Scan_Sig(row_a), .Column_Scan_Sig(col_a),
        .Digit_Idx(idx_a), .Frame_Start(fs_a)
    );

    smg_scan_ctrl #(.SEG_ACT_LOW(1), .DIG_ACT_LOW(0)) dut_b (
        .CLK(clk), .RST(rst), .Enable(en), .Digit_Data(data), .Blank_Mask(mask),
        .Brightness(bright), .Row_Scan_Sig(row_b), .Column_Scan_Sig(col_b),
        .Digit_Idx(idx_b), .Frame_Start(fs_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // lit cycles per 55-cycle slot with a 4-cycle guard (51 active cycles)
    function automatic int unsigned exp_duty(input logic [3:0] b);
        case (b)
            4'hF:    return 51;
            4'h8:    return 25;
            4'h0:    return 0;
            default: return (51 * int'(b)) / 16;
        endcase
    endfunction

    task automatic tick();
        exp_t        e;
        int unsigned pos, slot;
        logic        lit;
        e.due = cyc + 1;
        e.seg = '0;
        e.sel = '0;
        e.idx = '0;
        e.fs  = 1'b0;
        if (rst) begin
            m_t = 0;
        end else if (!en) begin
            e.idx = 3'((m_t / 55) % 6);
            m_t   = 0;
        end else begin
            pos   = m_t % 55;
            slot  = (m_t / 55) % 6;
            lit   = (pos >= 4) && ((pos - 4) < exp_duty(m_bright)) && !m_mask[slot];
            e.fs  = (m_t % 330) == 0;
            e.idx = 3'(slot);
            if (lit) begin
                e.seg = m_data[slot*8 +: 8];
                e.sel = 6'(1 << slot);
            end
            if ((m_t % 330) == 0) begin
                m_data   = data;
                m_mask   = mask;
                m_bright = bright;
            end
            m_t++;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int unsigned phase);
        for (int i = 0; i < 400 && (m_t % 330) != phase; i++) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if ({row_a, col_a, idx_a, fs_a} !== {e.seg, ~e.sel, e.idx, e.fs}) begin
                bad++;
                $display("FAIL scan_a cyc=%0d got row=%h col=%b idx=%0d fs=%b want row=%h col=%b idx=%0d fs=%b",
                         cyc, row_a, col_a, idx_a, fs_a, e.seg, ~e.sel, e.idx, e.fs);
            end
            total++;
            if ({row_b, col_b, idx_b, fs_b} !== {~e.seg, e.sel, e.idx, e.fs}) begin
                bad++;
                $display("FAIL scan_b cyc=%0d got row=%h col=%b idx=%0d fs=%b want row=%h col=%b idx=%0d fs=%b",
                         cyc, row_b, col_b, idx_b, fs_b, ~e.seg, e.sel, e.idx, e.fs);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        bright = 4'hF;
        mask   = '0;
        for (int i = 0; i < 6; i++) data[i*8 +: 8] = 8'(8'h10 + i);

        repeat (3) tick();
        rst = 1'b0;
        en  = 1'b1;
        repeat (660) tick();

        bright = 4'h8;
        repeat (330) tick();
        bright = 4'h0;
        repeat (330) tick();

        bright = 4'hF;
        mask   = 6'b000100;
        repeat (330) tick();

        run_to(100);
        data[7:0] = 8'hA5;
        mask      = '0;
        bright    = 4'h8;
        run_to(0);
        bright = 4'hF;
        repeat (330) tick();

        run_to(180);
        en = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        repeat (400) tick();

        run_to(240);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (400) tick();

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
